// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and related bus logic.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic       I2C_ACK        = 1'b0;
  localparam logic       I2C_NACK       = 1'b1;
  // Reserved for future 10-bit addressing.
  localparam logic [4:0] I2C_10B_PREFIX = 5'b11110;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus history flops; emits edge and START/STOP pulses.
// Flops reset to 1 (idle bus) so leaving reset never looks like a START.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;

  assign scl_sync_d[0] = scl_in;
  assign sda_sync_d[0] = sda_in;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      assign scl_sync_d[gi] = scl_sync_q[gi-1];
      assign sda_sync_d[gi] = sda_sync_q[gi-1];
    end
  endgenerate

  assign scl = scl_sync_q[SYNC_STAGES-1];
  assign sda = sda_sync_q[SYNC_STAGES-1];

  // History flops hold the previous synchronized level for edge detection.
  always_comb begin
    scl_hist_d = scl;
    sda_hist_d = sda;
  end

  // Synchronizer chain and history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_rise  =  scl & ~scl_hist_q;
  assign scl_fall  = ~scl &  scl_hist_q;
  assign start_det =  scl &  scl_hist_q & ~sda &  sda_hist_q;
  assign stop_det  =  scl &  scl_hist_q &  sda & ~sda_hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing, multi-byte write and read, no stretching.
import i2c_pkg::*;

module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       addr_hit,
  output logic       busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (I2C_SCL),
    .sda_in    (I2C_SDA),
    .scl       (scl_s),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           done_q, done_d;      // byte complete / master ACK seen, act on next fall
  logic           rw_q, rw_d;
  logic           sda_oe_q, sda_oe_d;  // 1 = pull SDA low
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           tx_req_q, tx_req_d;
  logic           tx_pend_q, tx_pend_d;
  logic           addr_hit_q, addr_hit_d;
  logic           busy_q, busy_d;

  // Next-state logic: START/STOP override, otherwise per-state bit handling.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    tx_pend_d  = tx_req_q;
    addr_hit_d = addr_hit_q;
    busy_d     = busy_q;

    // Read byte is taken two cycles after the request pulse.
    if (tx_pend_q) shift_d = tx_data;

    if (start_det) begin
      state_d    = ADDR;
      busy_d     = 1'b1;
      addr_hit_d = 1'b0;
      bitcnt_d   = 3'd7;
      sda_oe_d   = 1'b0;
      done_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
      sda_oe_d   = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_s};
            bitcnt_d = bitcnt_q - 3'd1;
            if (bitcnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d  = IGNORE;
              end
            end else begin
              if (rx_ready) begin
                sda_oe_d   = 1'b1;
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                sda_oe_d   = 1'b0;
              end
              state_d = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rw_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            addr_hit_d = 1'b1;
            bitcnt_d   = 3'd7;
            if (rw_q) begin
              sda_oe_d = ~shift_q[7];
              state_d  = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 3'd7;
            state_d  = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
              sda_oe_d = ~shift_q[bitcnt_q - 3'd1];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              state_d  = IGNORE;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = ~shift_q[7];
            bitcnt_d = 3'd7;
            state_d  = RD_DATA;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd7;
      shift_q    <= 8'h00;
      done_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      tx_pend_q  <= tx_pend_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
    end
  end

  assign I2C_SDA  = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master on an open-drain bus.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 80;  // quarter SCL period (8 clk cycles)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, busy;
  wire        sda_bus;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .I2C_SCL  (scl),
    .I2C_SDA  (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .addr_hit (addr_hit),
    .busy     (busy)
  );

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (tx_req === 1'b1) tx_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_low = ~b;
    #(Q); scl = 1'b1;
    #(Q); r = sda_bus;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic start_cond();
    m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b1;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic stop_cond();
    m_low = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b0;
    #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic r;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_sda", sda_bus, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_addr_hit", addr_hit, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Write 0xA5 to 0x42
    start_cond();
    chk("a_busy", busy, 1);
    send_byte(8'h84, ack);
    chk("a_addr_ack", ack, 0);
    chk("a_addr_hit", addr_hit, 1);
    send_byte(8'hA5, ack);
    chk("a_data_ack", ack, 0);
    chk("a_rx_cnt", rx_cnt, 1);
    chk("a_rx_data", rx_data, 8'hA5);
    stop_cond();
    chk("a_busy_stop", busy, 0);
    chk("a_hit_stop", addr_hit, 0);
    $display("txn A: write 0x42 <- a5 rx_data=%0h", rx_data);

    // Write to 0x43: not for us
    start_cond();
    send_byte(8'h86, ack);
    chk("b_addr_nack", ack, 1);
    chk("b_addr_hit", addr_hit, 0);
    send_byte(8'h12, ack);
    chk("b_data_nack", ack, 1);
    chk("b_rx_cnt", rx_cnt, 1);
    stop_cond();
    $display("txn B: write 0x43 ignored");

    // Read two bytes from 0x42
    tx_data = 8'h3C;
    start_cond();
    send_byte(8'h85, ack);
    chk("c_addr_ack", ack, 0);
    chk("c_addr_hit", addr_hit, 1);
    tx_data = 8'hC3;
    read_byte(1'b0, d);
    chk("c_byte1", d, 8'h3C);
    read_byte(1'b1, d);
    chk("c_byte2", d, 8'hC3);
    chk("c_sda_rel", sda_bus, 1);
    chk("c_tx_cnt", tx_cnt, 2);
    stop_cond();
    chk("c_tx_cnt_end", tx_cnt, 2);
    $display("txn C: read 0x42 -> 3c c3 tx_req=%0d", tx_cnt);

    // Write with client not ready
    rx_ready = 1'b0;
    start_cond();
    send_byte(8'h84, ack);
    chk("d_addr_ack", ack, 0);
    send_byte(8'h5A, ack);
    chk("d_data_nack", ack, 1);
    chk("d_rx_cnt", rx_cnt, 1);
    chk("d_rx_data", rx_data, 8'hA5);
    stop_cond();
    rx_ready = 1'b1;
    $display("txn D: write 0x42 <- 5a refused");

    // Write 0x11, repeated START, read
    start_cond();
    send_byte(8'h84, ack);
    send_byte(8'h11, ack);
    chk("e_data_ack", ack, 0);
    chk("e_rx_data", rx_data, 8'h11);
    chk("e_hit_before", addr_hit, 1);
    start_cond();
    chk("e_hit_rs", addr_hit, 0);
    chk("e_busy_rs", busy, 1);
    tx_data = 8'h96;
    send_byte(8'h85, ack);
    chk("e_addr_ack", ack, 0);
    chk("e_hit_again", addr_hit, 1);
    read_byte(1'b1, d);
    chk("e_rd", d, 8'h96);
    stop_cond();
    $display("txn E: write 11, rstart, read %0h", d);

    // Reset while the target holds SDA low for the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h84;
      bit_xfer(a[i], r);
    end
    m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q);
    chk("f_ack_low", sda_bus, 0);
    rst = 1'b1;
    #1;
    chk("f_sda_rel", sda_bus, 1);
    chk("f_busy", busy, 0);
    #(Q); scl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    start_cond();
    send_byte(8'h84, ack);
    chk("f_addr_ack", ack, 0);
    send_byte(8'h77, ack);
    chk("f_data_ack", ack, 0);
    chk("f_rx_data", rx_data, 8'h77);
    stop_cond();
    chk("f_busy_end", busy, 0);
    $display("txn F: reset mid-ack, then write 77");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
